// File: rtl/i2c_cmd_sched.sv
// ---------------------------------------------------------------------------
// i2c_cmd_sched
//
// Purpose:
//    Queues host memory commands (read/write, 7-bit address, 8-bit data) in a
//    small FIFO. It issues them one at a time to an I2C master ("I2C top") and
//    returns one response per command. Only one transaction is ever
//    outstanding. A transaction that does not complete within TIMEOUT wait
//    cycles is retired with an error response.
//
// Parameters:
//    DEPTH    command FIFO entries (power of two, 2..16)
//    TIMEOUT  wait-cycle limit for i2c_done per transaction
//
// Ports:
//    clk, rst                      clock, async active-high reset
//    cmd_valid/cmd_ready           host command handshake
//    cmd_wr, cmd_addr, cmd_data    command fields (data ignored for reads)
//    i2c_start                     one-cycle launch pulse to the I2C top
//    i2c_wr, i2c_addr, i2c_din     transaction fields, held for the whole txn
//    i2c_done, i2c_rdata           completion pulse and read data from I2C top
//    rsp_valid/rsp_ready           response handshake
//    rsp_data, rsp_err             read data (0 for writes/timeouts), timeout
//    busy                          scheduler active or commands pending
// ---------------------------------------------------------------------------
module i2c_cmd_sched #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_wr,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       i2c_start,
   output logic       i2c_wr,
   output logic [6:0] i2c_addr,
   output logic [7:0] i2c_din,
   input  logic       i2c_done,
   input  logic [7:0] i2c_rdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic       busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] TMO_C   = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t state;
   state_t next_state;

   // FIFO entry layout: {wr, addr[6:0], data[7:0]}
   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic [CW-1:0] wait_cnt;

   logic push;
   logic pop;
   logic timed_out;

   // Acceptance is based only on the registered count. A full FIFO never
   // takes a command, even on a cycle where the scheduler pops the head.
   assign cmd_ready = (count < DEPTH_C);
   assign push      = cmd_valid & cmd_ready;
   assign timed_out = (wait_cnt == TMO_C);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE) || (count != '0);

   // FIFO storage has no reset. Reset clears the pointers and count, so the
   // stale contents can never be read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= {cmd_wr, cmd_addr, cmd_data};
      end
   end

   // Pointer and occupancy bookkeeping. Pointers wrap naturally because DEPTH
   // is a power of two. A push and a pop in the same cycle cancel out in the
   // count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. The head of the FIFO is popped only from IDLE, which
   // keeps a single transaction in flight. i2c_done is looked at only in WAIT.
   // On the cycle where done and the timeout coincide, the transaction is
   // retired normally.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            next_state = WAIT;
         end
         WAIT: begin
            if (i2c_done || timed_out) begin
               next_state = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Transaction datapath. i2c_start is registered from the ISSUE state, so
   // the pulse is glitch-free and lasts one cycle. The transaction fields are
   // loaded only on a pop, so they hold from launch until the next command
   // is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i2c_start <= 1'b0;
         i2c_wr    <= 1'b0;
         i2c_addr  <= '0;
         i2c_din   <= '0;
         wait_cnt  <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         i2c_start <= (state == ISSUE);
         if (pop) begin
            {i2c_wr, i2c_addr, i2c_din} <= mem[rptr];
         end
         case (state)
            ISSUE: begin
               wait_cnt <= '0;
            end
            WAIT: begin
               if (i2c_done) begin
                  rsp_data <= i2c_wr ? 8'h00 : i2c_rdata;
                  rsp_err  <= 1'b0;
               end else if (timed_out) begin
                  rsp_data <= 8'h00;
                  rsp_err  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: begin
               wait_cnt <= wait_cnt;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_i2c_cmd_sched
//
// Purpose:
//    Self-checking bench for i2c_cmd_sched (DEPTH=4, TIMEOUT=255).
//    Commands are randomised. A queue of accepted commands gives the expected
//    launch order and fields. Responses are worked out from the command and
//    the completion the bench chose to drive.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_i2c_cmd_sched;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 255;

   typedef struct packed {
      logic       wr;
      logic [6:0] addr;
      logic [7:0] data;
   } cmd_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_wr;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       i2c_start;
   logic       i2c_wr;
   logic [6:0] i2c_addr;
   logic [7:0] i2c_din;
   logic       i2c_done;
   logic [7:0] i2c_rdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       busy;

   cmd_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_starts = 0;
   int   cyc      = 0;
   int   last_start_cyc = 0;

   i2c_cmd_sched #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_wr    (cmd_wr),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .i2c_start (i2c_start),
      .i2c_wr    (i2c_wr),
      .i2c_addr  (i2c_addr),
      .i2c_din   (i2c_din),
      .i2c_done  (i2c_done),
      .i2c_rdata (i2c_rdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Free-running cycle counter, used to measure latencies
   always @(posedge clk) begin
      cyc++;
   end

   // Record every launch pulse, mid-cycle, so the bench can count starts
   // and time the timeout from the launch
   always @(negedge clk) begin
      if (i2c_start) begin
         n_starts++;
         last_start_cyc = cyc;
      end
   end

   // Hard stop in case the bench itself loses its way
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer one command for up to 'budget' cycles; it is accepted on the
   // edge following a cycle where cmd_ready was seen high
   task automatic apply_stimulus(input logic wr, input logic [6:0] addr, input logic [7:0] data,
                                 input int budget, output bit accepted);
      cmd_t c;
      accepted  = 1'b0;
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = addr;
      cmd_data  = data;
      for (int i = 0; i < budget && !accepted; i++) begin
         if (cmd_ready) begin
            accepted = 1'b1;
            c = '{wr: wr, addr: addr, data: data};
            exp_q.push_back(c);
         end
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (i2c_start) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   // Match the launched transaction against the oldest accepted command
   task automatic take_start(input bit already, output bit ok, output cmd_t c);
      c  = '0;
      ok = already;
      if (!already) begin
         wait_start(60, ok);
         check_output("start_seen", 32'(ok), 32'd1);
      end
      if (ok) begin
         check_output("pending_cmd_exists", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() == 0) begin
            ok = 1'b0;
         end else begin
            c = exp_q.pop_front();
            check_output("i2c_fields", 32'({i2c_wr, i2c_addr, i2c_din}), 32'(c));
         end
      end
   endtask

   // Complete the in-flight transaction, either with i2c_done after 'delay'
   // further cycles or by withholding done until it times out
   task automatic finish_txn(input cmd_t c, input bit give_done, input int delay, input logic [7:0] rdata);
      logic [7:0] exp_data;
      logic       exp_err;
      int         guard;
      if (give_done) begin
         repeat (delay) begin
            @(posedge clk);
            #1;
         end
         i2c_done  = 1'b1;
         i2c_rdata = rdata;
         @(posedge clk);
         #1;
         i2c_done  = 1'b0;
         i2c_rdata = 8'($urandom);
         exp_data  = c.wr ? 8'h00 : rdata;
         exp_err   = 1'b0;
         check_output("rsp_valid_after_done", 32'(rsp_valid), 32'd1);
      end else begin
         guard = 0;
         while (!rsp_valid && guard < TIMEOUT + 20) begin
            @(posedge clk);
            #1;
            guard++;
         end
         exp_data = 8'h00;
         exp_err  = 1'b1;
         check_output("timeout_latency", 32'(cyc - last_start_cyc), 32'(TIMEOUT + 1));
      end
      check_output("rsp_data", 32'(rsp_data), 32'(exp_data));
      check_output("rsp_err", 32'(rsp_err), 32'(exp_err));
   endtask

   task automatic accept_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check_output("rsp_valid_after_accept", 32'(rsp_valid), 32'd0);
   endtask

   // Directed and randomised steps, run in order
   initial begin
      bit         acc;
      bit         ok;
      bit         stable;
      cmd_t       c;
      int         s0;
      logic       wr;
      logic [7:0] rd;

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_wr    = 1'b0;
      cmd_addr  = '0;
      cmd_data  = '0;
      i2c_done  = 1'b0;
      i2c_rdata = '0;
      rsp_ready = 1'b0;

      // Reset values
      #1;
      check_output("rst_i2c_start", 32'(i2c_start), 32'd0);
      check_output("rst_fields", 32'({i2c_wr, i2c_addr, i2c_din}), 32'd0);
      check_output("rst_rsp", 32'({rsp_valid, rsp_data, rsp_err}), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_output("ready_after_reset", 32'(cmd_ready), 32'd1);

      // Write 0x12 <- 0xA5: launch timing, pulse width, done after 10 cycles
      apply_stimulus(1'b1, 7'h12, 8'hA5, 5, acc);
      check_output("push_write", 32'(acc), 32'd1);
      check_output("start_not_early", 32'(i2c_start), 32'd0);
      @(posedge clk);
      #1;
      check_output("start_not_early_2", 32'(i2c_start), 32'd0);
      check_output("busy_active", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check_output("start_latency", 32'(i2c_start), 32'd1);
      take_start(1'b1, ok, c);
      @(posedge clk);
      #1;
      check_output("start_one_cycle", 32'(i2c_start), 32'd0);
      finish_txn(c, 1'b1, 8, 8'h3C);
      accept_rsp();

      // Read 0x12 returning 0x5C
      apply_stimulus(1'b0, 7'h12, 8'h00, 5, acc);
      take_start(1'b0, ok, c);
      if (ok) finish_txn(c, 1'b1, 4, 8'h5C);
      accept_rsp();

      // Stray done while idle is ignored
      i2c_done  = 1'b1;
      i2c_rdata = 8'hEE;
      @(posedge clk);
      #1;
      i2c_done = 1'b0;
      check_output("idle_done_ignored", 32'({rsp_valid, busy}), 32'd0);

      // Randomised commands, completion delays and read data
      for (int i = 0; i < 8; i++) begin
         wr = 1'($urandom_range(0, 1));
         apply_stimulus(wr, 7'($urandom), 8'($urandom), 5, acc);
         take_start(1'b0, ok, c);
         if (ok) finish_txn(c, 1'b1, $urandom_range(0, 30), 8'($urandom_range(1, 255)));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         accept_rsp();
      end

      // Done arriving on the very cycle the timeout would fire wins
      apply_stimulus(1'b0, 7'h55, 8'h00, 5, acc);
      take_start(1'b0, ok, c);
      if (ok) finish_txn(c, 1'b1, TIMEOUT, 8'hC3);
      accept_rsp();

      // Fill: one in flight plus DEPTH queued, then the FIFO refuses more
      s0 = n_starts;
      for (int i = 0; i < 5; i++) begin
         apply_stimulus((i == 0 || i == 4), 7'(8'h40 + i), 8'($urandom), 3, acc);
         check_output("push_fill", 32'(acc), 32'd1);
      end
      check_output("ready_low_when_full", 32'(cmd_ready), 32'd0);
      check_output("one_issued", 32'(n_starts - s0), 32'd1);
      apply_stimulus(1'b1, 7'h7F, 8'hFF, 5, acc);
      check_output("push_refused_when_full", 32'(acc), 32'd0);

      // First command times out
      take_start(1'b1, ok, c);
      if (ok) finish_txn(c, 1'b0, 0, 8'h00);

      // Response held while rsp_ready is low; stray done ignored in RESP
      s0     = n_starts;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) begin
            i2c_done  = 1'b1;
            i2c_rdata = 8'h77;
         end
         @(posedge clk);
         #1;
         i2c_done = 1'b0;
         if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_err !== 1'b1) stable = 1'b0;
      end
      check_output("rsp_held_stable", 32'(stable), 32'd1);
      check_output("no_start_while_resp", 32'(n_starts - s0), 32'd0);
      accept_rsp();

      // Remaining queued commands launch in push order
      take_start(1'b0, ok, c);
      if (ok) finish_txn(c, 1'b1, $urandom_range(0, 10), 8'($urandom));
      accept_rsp();
      check_output("ready_after_drain", 32'(cmd_ready), 32'd1);
      take_start(1'b0, ok, c);
      rd = 8'($urandom_range(1, 255));
      if (ok) finish_txn(c, 1'b1, $urandom_range(0, 10), rd);
      accept_rsp();
      take_start(1'b0, ok, c);

      // Asynchronous reset while waiting on the fourth command
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      check_output("wait_rst_i2c_start", 32'(i2c_start), 32'd0);
      check_output("wait_rst_fields", 32'({i2c_wr, i2c_addr, i2c_din}), 32'd0);
      check_output("wait_rst_rsp", 32'({rsp_valid, rsp_data, rsp_err}), 32'd0);
      check_output("wait_rst_busy", 32'(busy), 32'd0);
      check_output("wait_rst_ready", 32'(cmd_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      s0  = n_starts;
      repeat (10) @(posedge clk);
      #1;
      check_output("queue_discarded", 32'(n_starts - s0), 32'd0);
      check_output("idle_after_rst", 32'({busy, rsp_valid}), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
